// File: rtl/rect_plotter.sv
// Rectangle-fill pixel generator for the vga_adapter write port: one clipped pixel
// per clock in raster order, with start/busy/done handshake plus pause and abort.
module rect_plotter #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W-1:0]     w,
  input  logic [Y_W-1:0]     h,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               pause,
  input  logic               abort,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] color,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam logic [X_W:0] SW = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SH = (Y_W+1)'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

  state_t         state;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic [X_W-1:0] x_start;
  logic [X_W:0]   x_end;
  logic [Y_W:0]   y_end;

  // Clipped extent of the incoming command, one bit wider than the coordinates
  logic [X_W:0] room_x, we_c, x_end_c;
  logic [Y_W:0] room_y, he_c, y_end_c;
  logic         empty, single;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    room_x  = '0;
    room_y  = '0;
    if ({1'b0, x0} < SW) room_x = SW - {1'b0, x0};
    if ({1'b0, y0} < SH) room_y = SH - {1'b0, y0};
    we_c    = ({1'b0, w} < room_x) ? {1'b0, w} : room_x;
    he_c    = ({1'b0, h} < room_y) ? {1'b0, h} : room_y;
    empty   = (we_c == '0) || (he_c == '0);
    single  = (we_c == (X_W+1)'(1)) && (he_c == (Y_W+1)'(1));
    x_end_c = {1'b0, x0} + we_c - (X_W+1)'(1);
    y_end_c = {1'b0, y0} + he_c - (Y_W+1)'(1);
  end

  logic at_row_end, at_last;
  always_comb begin
    at_row_end = ({1'b0, cx} == x_end);
    at_last    = at_row_end && ({1'b0, cy} == y_end);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cx      <= '0;
      cy      <= '0;
      x_start <= '0;
      x_end   <= '0;
      y_end   <= '0;
      x       <= '0;
      y       <= '0;
      color   <= '0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          plot <= 1'b0;
          if (start) begin
            if (empty) begin
              done <= 1'b1;
            end else begin
              // First pixel goes out on the accept edge; cursor moves past it.
              x_start <= x0;
              x_end   <= x_end_c;
              y_end   <= y_end_c;
              x       <= x0;
              y       <= y0;
              color   <= color_in;
              plot    <= 1'b1;
              busy    <= 1'b1;
              if (we_c == (X_W+1)'(1)) begin
                cx <= x0;
                cy <= y0 + Y_W'(1);
              end else begin
                cx <= x0 + X_W'(1);
                cy <= y0;
              end
              state <= single ? FINISH : DRAW;
            end
          end
        end

        DRAW: begin
          if (abort) begin
            plot  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (pause) begin
            plot <= 1'b0;
          end else begin
            x    <= cx;
            y    <= cy;
            plot <= 1'b1;
            if (at_last) begin
              state <= FINISH;
            end else if (at_row_end) begin
              cx <= x_start;
              cy <= cy + Y_W'(1);
            end else begin
              cx <= cx + X_W'(1);
            end
          end
        end

        FINISH: begin
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          plot  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
